// File: rtl/wash_pkg.sv
// Shared washer state encoding; the enum value doubles as the phase code on the port.
package wash_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_WASH  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_SPIN  = 3'd4,
        ST_DONE  = 3'd5,
        ST_FAULT = 3'd6
    } wash_state_t;

    localparam int RINSE_W = 3;

    // Running states keep the door locked and treat an opened door as a fault.
    function automatic logic is_running(input wash_state_t s);
        return (s == ST_FILL) || (s == ST_WASH) || (s == ST_DRAIN) || (s == ST_SPIN);
    endfunction

endpackage

// File: rtl/wash_timer.sv
// Phase timer: cleared on state entry, counts enabled ticks, saturates, flags the enabled tick that reaches the limit.
module wash_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] cmp_val,
    output logic             expire
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign expire = en && (count >= cmp_val);

endmodule

// File: rtl/wash_ctrl_param.sv
// Washing machine sequencer: fill/wash/drain passes with rinses, spin, done, and a safe drain-only fault state.
module wash_ctrl_param
    import wash_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int WASH_NORMAL = 1000,
    parameter int WASH_QUICK  = 400,
    parameter int SPIN_TICKS  = 300,
    parameter int RINSE_N     = 2,
    parameter int FILL_LIMIT  = 2000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               start,
    input  logic               door_close,
    input  logic               filled,
    input  logic               drained,
    input  logic               quick_wash,
    input  logic               detergent_added,
    input  logic               pause,
    input  logic               clear,
    output logic               door_lock,
    output logic               fill_valve_on,
    output logic               water_wash,
    output logic               soap_wash,
    output logic               motor_on,
    output logic               drain_valve_on,
    output logic               done,
    output logic               fault,
    output logic [2:0]         phase,
    output logic [RINSE_W-1:0] rinse_left
);

    localparam logic [CNT_W-1:0]   WASH_N_LAST = CNT_W'(WASH_NORMAL - 1);
    localparam logic [CNT_W-1:0]   WASH_Q_LAST = CNT_W'(WASH_QUICK - 1);
    localparam logic [CNT_W-1:0]   SPIN_LAST   = CNT_W'(SPIN_TICKS - 1);
    localparam logic [CNT_W-1:0]   LIMIT_LAST  = CNT_W'(FILL_LIMIT - 1);
    localparam logic [RINSE_W-1:0] RINSE_INIT  = RINSE_W'(RINSE_N);

    wash_state_t      state, next_state;
    logic             mode, soap_pass, det_latched;
    logic             tmr_en, tmr_clr, expire, fault_req;
    logic [CNT_W-1:0] cmp_val;

    assign tmr_en  = tick && !pause;
    assign tmr_clr = (next_state != state);
    assign phase   = state;

    always_comb begin
        case (state)
            ST_WASH: cmp_val = mode ? WASH_Q_LAST : WASH_N_LAST;
            ST_SPIN: cmp_val = SPIN_LAST;
            default: cmp_val = LIMIT_LAST;
        endcase
    end

    wash_timer #(.CNT_W(CNT_W)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .cmp_val (cmp_val),
        .expire  (expire)
    );

    // Pause freezes the sequence, but a door opening or a fill/drain timeout always wins and goes to FAULT.
    always_comb begin
        next_state = state;
        fault_req  = (is_running(state) && !door_close) ||
                     (((state == ST_FILL) || (state == ST_DRAIN)) && expire);
        case (state)
            ST_IDLE:  if (start && door_close) next_state = ST_FILL;
            ST_FILL:  if (filled && !pause) next_state = ST_WASH;
            ST_WASH:  if (expire) next_state = ST_DRAIN;
            ST_DRAIN: if (drained && !pause) next_state = (rinse_left != '0) ? ST_FILL : ST_SPIN;
            ST_SPIN:  if (expire) next_state = ST_DONE;
            ST_DONE:  if (clear || !door_close) next_state = ST_IDLE;
            ST_FAULT: if (clear && drained) next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
        if (fault_req) next_state = ST_FAULT;
    end

    // Outputs decode the next state so they change on the same edge as the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= ST_IDLE;
            mode           <= 1'b0;
            soap_pass      <= 1'b0;
            det_latched    <= 1'b0;
            rinse_left     <= '0;
            door_lock      <= 1'b0;
            fill_valve_on  <= 1'b0;
            water_wash     <= 1'b0;
            soap_wash      <= 1'b0;
            motor_on       <= 1'b0;
            drain_valve_on <= 1'b0;
            done           <= 1'b0;
            fault          <= 1'b0;
        end else begin
            state <= next_state;
            if ((state == ST_IDLE) && (next_state == ST_FILL)) begin
                mode        <= quick_wash;
                rinse_left  <= RINSE_INIT;
                soap_pass   <= 1'b1;
                det_latched <= detergent_added;
            end else if ((state == ST_DRAIN) && (next_state == ST_FILL)) begin
                rinse_left <= rinse_left - 1'b1;
                soap_pass  <= 1'b0;
            end
            door_lock      <= is_running(next_state) || (next_state == ST_FAULT);
            fill_valve_on  <= (next_state == ST_FILL) && !pause;
            motor_on       <= ((next_state == ST_WASH) || (next_state == ST_SPIN)) && !pause;
            soap_wash      <= (next_state == ST_WASH) && !pause && soap_pass && det_latched;
            water_wash     <= (next_state == ST_WASH) && !pause && !(soap_pass && det_latched);
            drain_valve_on <= (next_state == ST_DRAIN) || (next_state == ST_SPIN) ||
                              (next_state == ST_FAULT);
            done           <= (next_state == ST_DONE);
            fault          <= (next_state == ST_FAULT);
        end
    end

endmodule

// File: tb/tb_wash_ctrl_param.sv
// Randomized scoreboard bench: each wash run queues its expected phase visits, a negedge monitor checks them.
module tb_wash_ctrl_param;

    localparam int CNT_W = 8, WASH_NORMAL = 8, WASH_QUICK = 3, SPIN_TICKS = 4;
    localparam int RINSE_N = 1, FILL_LIMIT = 5;
    localparam int P_IDLE = 0, P_FILL = 1, P_WASH = 2, P_DRAIN = 3, P_SPIN = 4, P_DONE = 5, P_FAULT = 6;
    localparam int K_NORMAL = 0, K_FILL_FAULT = 1, K_DOOR_FAULT = 2, K_RESET = 3;

    logic clk = 1'b0, rst = 1'b0;
    logic tick = 0, start = 0, door_close = 0, filled = 0, drained = 0;
    logic quick_wash = 0, detergent_added = 0, pause = 0, clear = 0;
    logic door_lock, fill_valve_on, water_wash, soap_wash, motor_on, drain_valve_on, done, fault;
    logic [2:0] phase, rinse_left;
    logic [7:0] outs_vec;

    assign outs_vec = {door_lock, fill_valve_on, water_wash, soap_wash,
                       motor_on, drain_valve_on, done, fault};

    always #5 clk = ~clk;

    wash_ctrl_param #(
        .CNT_W(CNT_W), .WASH_NORMAL(WASH_NORMAL), .WASH_QUICK(WASH_QUICK),
        .SPIN_TICKS(SPIN_TICKS), .RINSE_N(RINSE_N), .FILL_LIMIT(FILL_LIMIT)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .door_close(door_close),
        .filled(filled), .drained(drained), .quick_wash(quick_wash),
        .detergent_added(detergent_added), .pause(pause), .clear(clear),
        .door_lock(door_lock), .fill_valve_on(fill_valve_on), .water_wash(water_wash),
        .soap_wash(soap_wash), .motor_on(motor_on), .drain_valve_on(drain_valve_on),
        .done(done), .fault(fault), .phase(phase), .rinse_left(rinse_left)
    );

    typedef struct {
        int         phase;
        logic [7:0] outs;
        int         rinse;
        int         ticks;
        int         min_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0, n_err = 0;

    // Actuator pattern of each phase when not paused: {lock,fill,water,soap,motor,drain,done,fault}.
    function automatic logic [7:0] outs_of(input int ph, input bit soap);
        case (ph)
            P_FILL:  return 8'b1100_0000;
            P_WASH:  return soap ? 8'b1001_1000 : 8'b1010_1000;
            P_DRAIN: return 8'b1000_0100;
            P_SPIN:  return 8'b1000_1100;
            P_DONE:  return 8'b0000_0010;
            P_FAULT: return 8'b1000_0101;
            default: return 8'b0000_0000;
        endcase
    endfunction

    task automatic check_output(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int ph, input int rinse, input int ticks, input int min_cyc, input bit soap);
        exp_t e;
        e.phase = ph; e.outs = outs_of(ph, soap); e.rinse = rinse;
        e.ticks = ticks; e.min_cyc = min_cyc;
        exp_q.push_back(e);
    endtask

    // Monitor: a new phase pops one expectation; leaving a phase checks its enabled-tick count.
    initial begin
        int   last_phase = P_IDLE, cyc = 0, ticks_in = 0;
        bit   pause_prev = 0, have_cur = 0;
        exp_t cur;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (int'(phase) != last_phase) begin
                    if (have_cur && cur.ticks >= 0) check_output("phase_ticks", ticks_in, cur.ticks);
                    if (have_cur && cur.min_cyc > 0) check_output("phase_min_cycles", int'(cyc >= cur.min_cyc), 1);
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_err++; have_cur = 0;
                        $display("[TB] FAIL unexpected_phase: got %0d, expected none at %0t", phase, $time);
                    end else begin
                        cur = exp_q.pop_front();
                        have_cur = 1;
                        check_output("phase", int'(phase), cur.phase);
                        check_output("entry_outputs", int'(outs_vec), int'(cur.outs));
                        if (cur.rinse >= 0) check_output("rinse_left", int'(rinse_left), cur.rinse);
                    end
                    last_phase = int'(phase); cyc = 0; ticks_in = 0;
                end
                cyc++;
                if (tick && !pause) ticks_in++;
                if (int'(phase) == P_WASH) check_output("wash_motor_vs_pause", int'(motor_on), int'(!pause_prev));
            end
            pause_prev = pause;
        end
    end

    task automatic door_open_test();
        door_close = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            start = 1; tick = 1;
        end
        @(posedge clk); #1;
        start = 0;
        @(negedge clk);
        check_output("door_open_phase", int'(phase), P_IDLE);
        check_output("door_open_lock", int'(door_lock), 0);
    endtask

    task automatic apply_stimulus(input int kind, input bit q, input bit d, input bit do_pause);
        int wl = q ? WASH_QUICK : WASH_NORMAL;
        int prev = P_IDLE, j = 0, wait_n = 0, ph;
        bit started = 0, finished = 0;
        if (kind == K_FILL_FAULT) begin
            push(P_FILL, RINSE_N, FILL_LIMIT, 0, 0);
            push(P_FAULT, -1, -1, 4, 0);
            push(P_IDLE, -1, -1, 0, 0);
        end else if (kind == K_RESET) begin
            push(P_FILL, RINSE_N, -1, 0, 0);
            push(P_WASH, RINSE_N, -1, 0, d);
            push(P_IDLE, 0, -1, 0, 0);
        end else begin
            for (int p = 0; p <= RINSE_N; p++) begin
                push(P_FILL, RINSE_N - p, -1, 0, 0);
                push(P_WASH, RINSE_N - p, wl, 0, (p == 0) && d);
                push(P_DRAIN, RINSE_N - p, -1, 0, 0);
            end
            if (kind == K_DOOR_FAULT) begin
                push(P_SPIN, 0, -1, 0, 0);
                push(P_FAULT, -1, -1, 4, 0);
                push(P_IDLE, -1, -1, 0, 0);
            end else begin
                push(P_SPIN, 0, SPIN_TICKS, 0, 0);
                push(P_DONE, 0, -1, 0, 0);
                push(P_IDLE, 0, -1, 0, 0);
            end
        end
        for (int it = 0; it < 600 && !finished; it++) begin
            @(posedge clk); #1;
            ph = int'(phase);
            if (ph != prev) begin
                j = 0; wait_n = $urandom_range(0, 2); prev = ph;
            end
            j++;
            start = 0; filled = 0; drained = 0; clear = 0; pause = 0;
            tick = ($urandom_range(0, 3) != 0);
            quick_wash = 1'($urandom); detergent_added = 1'($urandom);
            case (ph)
                P_IDLE: begin
                    if (!started) begin
                        start = 1; door_close = 1; quick_wash = q; detergent_added = d; started = 1;
                    end else finished = 1;
                end
                P_FILL:  if (kind != K_FILL_FAULT && j == wait_n + 1) filled = 1;
                P_WASH: begin
                    if (do_pause && j >= 2 && j < 22) pause = 1;
                    if (kind == K_RESET && j == 3) begin
                        #2 rst = 0;
                        #1;
                        check_output("reset_outputs", int'(outs_vec), 0);
                        check_output("reset_phase", int'(phase), P_IDLE);
                        check_output("reset_rinse_left", int'(rinse_left), 0);
                        repeat (2) @(posedge clk);
                        #1 rst = 1;
                        finished = 1;
                    end
                end
                P_DRAIN: if (j == wait_n + 1) drained = 1;
                P_SPIN:  if (kind == K_DOOR_FAULT && j == 2) door_close = 0;
                P_DONE:  if ($urandom_range(0, 1) != 0) clear = 1; else door_close = 0;
                P_FAULT: begin
                    clear = 1;
                    if (j >= 4) drained = 1;
                end
                default: ;
            endcase
        end
        if (!finished) begin
            n_cmp++; n_err++;
            $display("[TB] FAIL run_timeout: got no return to IDLE, expected one within 600 cycles (kind %0d)", kind);
        end
        start = 0; filled = 0; drained = 0; clear = 0; pause = 0;
    endtask

    initial begin
        #3;
        check_output("por_outputs", int'(outs_vec), 0);
        check_output("por_phase", int'(phase), P_IDLE);
        repeat (2) @(posedge clk);
        #1 rst = 1;
        door_open_test();
        apply_stimulus(K_NORMAL, 0, 1, 0);
        apply_stimulus(K_NORMAL, 1, 0, 1);
        for (int i = 0; i < 4; i++)
            apply_stimulus(K_NORMAL, 1'($urandom), 1'($urandom), 1'($urandom));
        apply_stimulus(K_FILL_FAULT, 1'($urandom), 1'($urandom), 0);
        apply_stimulus(K_DOOR_FAULT, 1'($urandom), 1'($urandom), 0);
        apply_stimulus(K_RESET, 0, 1, 0);
        apply_stimulus(K_NORMAL, 1, 1, 1);
        repeat (3) @(posedge clk);
        check_output("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wash_ctrl_param.md
WASH_CTRL_PARAM -- requirements
Module: wash_ctrl_param

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of internal phase timer.
REQ-002 SHALL have parameter WASH_NORMAL, default 1000, wash duration in ticks, normal mode.
REQ-003 SHALL have parameter WASH_QUICK, default 400, wash duration in ticks, quick mode.
REQ-004 SHALL have parameter SPIN_TICKS, default 300, spin duration in ticks.
REQ-005 SHALL have parameter RINSE_N, default 2, rinse passes after soap wash (0..7).
REQ-006 SHALL have parameter FILL_LIMIT, default 2000, max ticks in FILL or DRAIN before fault.
REQ-007 Ports: clk in 1 clock; rst in 1 asynchronous active-low reset.
REQ-008 Ports: tick in 1 timebase enable; start in 1 cycle request; door_close in 1 door sensor; filled in 1 level sensor; drained in 1 empty sensor.
REQ-009 Ports: quick_wash in 1 mode select; detergent_added in 1 soap present; pause in 1 user pause; clear in 1 fault/done acknowledge.
REQ-010 Ports: door_lock, fill_valve_on, water_wash, soap_wash, motor_on, drain_valve_on, done, fault out 1 each; phase out 3 state code; rinse_left out 3 remaining rinses.

Function
REQ-011 FSM states SHALL be IDLE, FILL, WASH, DRAIN, SPIN, DONE, FAULT, encoded 0..6 on phase.
REQ-012 IDLE->FILL SHALL occur when start=1 and door_close=1 in same cycle; start with door open ignored.
REQ-013 On IDLE->FILL, quick_wash SHALL be latched as mode; rinse_left loaded with RINSE_N; first pass flagged soap pass.
REQ-014 FILL: fill_valve_on=1; FILL->WASH when filled=1; timer cleared on every state entry.
REQ-015 WASH: motor_on=1; soap_wash=1 on soap pass if detergent_added latched at FILL entry, else water_wash=1; rinse passes always water_wash=1.
REQ-016 WASH->DRAIN when timer reaches WASH_QUICK-1 (mode=1) or WASH_NORMAL-1 (mode=0) on a tick.
REQ-017 DRAIN: drain_valve_on=1; on drained=1: if rinse_left>0 decrement and go FILL (rinse pass), else go SPIN.
REQ-018 SPIN: motor_on=1, drain_valve_on=1; SPIN->DONE when timer reaches SPIN_TICKS-1 on a tick.
REQ-019 DONE: done=1, door_lock=0; DONE->IDLE on clear=1 or door_close=0.
REQ-020 door_lock SHALL be 1 in FILL, WASH, DRAIN, SPIN and FAULT.
REQ-021 Timer SHALL advance only when tick=1 and pause=0; CNT_W-bit, saturating, never wraps.
REQ-022 pause=1 SHALL force fill_valve_on, motor_on, soap_wash, water_wash to 0 while holding state and timer; drain_valve_on held.
REQ-023 FILL or DRAIN timer reaching FILL_LIMIT SHALL go FAULT; door_close=0 in any locked non-FAULT state SHALL go FAULT.
REQ-024 FAULT: fault=1, drain_valve_on=1, all other actuators 0; FAULT->IDLE only on clear=1 and drained=1.
REQ-025 Outputs SHALL be registered (one-cycle latency from state change); simultaneous FAULT condition and normal transition SHALL resolve to FAULT.
REQ-026 start during non-IDLE states SHALL be ignored.

Reset
REQ-027 rst=0 SHALL asynchronously force IDLE, timer 0, rinse_left 0, mode 0, all outputs 0, phase 0, including mid-cycle.
REQ-028 Deassertion SHALL take effect at the next clk rising edge; no actuator SHALL glitch high during reset.

Structure
REQ-029 State encodings and phase codes SHALL live in shared package wash_pkg.
REQ-030 Phase timer (clear, enable, saturate, compare) SHALL be sub-module wash_timer; FSM and output decode in top.

Verification
REQ-031 Normal: RINSE_N=1, WASH_NORMAL=8, start+door, filled, drained pulses, tick=1 -> phases FILL,WASH(8 ticks, soap_wash),DRAIN,FILL,WASH(water_wash),DRAIN,SPIN,DONE; done=1.
REQ-032 Quick: quick_wash=1, WASH_QUICK=3 -> WASH lasts exactly 3 ticks; quick_wash change mid-cycle has no effect.
REQ-033 Pause: pause=1 for 20 cycles in WASH -> motor_on=0, timer frozen, WASH resumes remaining ticks after release.
REQ-034 Faults: door_close=0 in SPIN -> fault=1, drain_valve_on=1; filled never asserted with FILL_LIMIT=5 -> FAULT after 5 ticks; clear with drained=1 -> IDLE.
REQ-035 Reset mid-WASH: rst=0 -> all outputs 0 immediately (before next clk), phase=0.
REQ-036 Start with door_close=0 -> remains IDLE, door_lock=0.
